// File: rtl/avalon_rd_burst_arbiter.sv
// Two-requester round-robin arbiter in front of one Avalon-MM burst read master.
// Accepted bursts are tagged in an in-order FIFO so returning beats reach their issuer.
module avalon_rd_burst_arbiter #(
    parameter int AW          = 17,
    parameter int DW          = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AW-1:0]                  rq0_address,
    input  logic                           rq0_read,
    input  logic [5:0]                     rq0_burstcount,
    output logic                           rq0_waitrequest,
    output logic                           rq0_readdatavalid,
    input  logic [AW-1:0]                  rq1_address,
    input  logic                           rq1_read,
    input  logic [5:0]                     rq1_burstcount,
    output logic                           rq1_waitrequest,
    output logic                           rq1_readdatavalid,
    output logic [DW-1:0]                  rq_read_data,
    output logic [AW-1:0]                  avalon_rd_address,
    output logic                           avalon_rd_read,
    output logic [5:0]                     avalon_rd_burstcount,
    input  logic                           avalon_rd_waitrequest,
    input  logic                           avalon_rd_readdatavalid,
    input  logic [DW-1:0]                  avalon_rd_readdata,
    output logic [$clog2(MAX_PENDING):0]   pending,
    output logic                           err_unexpected
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t          state, state_n;
    logic            last_grant;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count, level_after;
    logic            id_mem [MAX_PENDING];
    logic [5:0]      bc_mem [MAX_PENDING];
    logic [5:0]      beat_cnt, beat_rem;
    logic            full, empty, push, pop, sel1;
    logic            cur_read, other_read, cur_wait, head_id, beat_ok;

    assign full  = (count == FULL_LVL);
    assign empty = (count == '0);
    assign sel1  = (state == BUSY1);

    assign avalon_rd_address    = sel1 ? rq1_address    : rq0_address;
    assign avalon_rd_burstcount = sel1 ? rq1_burstcount : rq0_burstcount;
    assign cur_read             = sel1 ? rq1_read       : rq0_read;
    assign other_read           = sel1 ? rq0_read       : rq1_read;

    // Post-push level is taken against the pre-pop count: a same-cycle pop never frees a slot early.
    assign level_after = count + {{PW{1'b0}}, push};

    always_comb begin
        state_n        = state;
        avalon_rd_read = 1'b0;
        cur_wait       = 1'b1;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (!full && (rq0_read || rq1_read)) begin
                    if (rq0_read && (!rq1_read || last_grant))
                        state_n = BUSY0;
                    else
                        state_n = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                cur_wait = avalon_rd_waitrequest;
                if (!cur_read) begin
                    state_n = IDLE;
                end else begin
                    if (avalon_rd_burstcount == 6'd0) begin
                        cur_wait = 1'b0;
                    end else begin
                        avalon_rd_read = 1'b1;
                        push           = !avalon_rd_waitrequest;
                    end
                    if (avalon_rd_burstcount == 6'd0 || push) begin
                        if (level_after == FULL_LVL)
                            state_n = IDLE;
                        else if (other_read)
                            state_n = sel1 ? BUSY0 : BUSY1;
                        else
                            state_n = state;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rq0_waitrequest = (state == BUSY0) ? cur_wait : 1'b1;
    assign rq1_waitrequest = (state == BUSY1) ? cur_wait : 1'b1;

    assign head_id  = id_mem[rd_ptr];
    assign beat_rem = (beat_cnt == 6'd0) ? bc_mem[rd_ptr] : beat_cnt;
    assign beat_ok  = avalon_rd_readdatavalid && !empty;
    assign pop      = beat_ok && (beat_rem == 6'd1);

    assign rq_read_data      = avalon_rd_readdata;
    assign rq0_readdatavalid = beat_ok && !head_id;
    assign rq1_readdatavalid = beat_ok && head_id;
    assign pending           = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat_cnt       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            state <= state_n;
            if (push) begin
                last_grant <= sel1;
                wr_ptr     <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
            if (beat_ok)
                beat_cnt <= beat_rem - 6'd1;
            if (avalon_rd_readdatavalid && empty)
                err_unexpected <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= sel1;
            bc_mem[wr_ptr] <= avalon_rd_burstcount;
        end
    end

endmodule

// File: tb/tb_avalon_rd_burst_arbiter.sv
// Directed self-checking bench for avalon_rd_burst_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_avalon_rd_burst_arbiter;

    localparam int AW = 17;
    localparam int DW = 16;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rq0_address, rq1_address;
    logic          rq0_read, rq1_read;
    logic [5:0]    rq0_burstcount, rq1_burstcount;
    logic          rq0_waitrequest, rq1_waitrequest;
    logic          rq0_readdatavalid, rq1_readdatavalid;
    logic [DW-1:0] rq_read_data;
    logic [AW-1:0] avalon_rd_address;
    logic          avalon_rd_read;
    logic [5:0]    avalon_rd_burstcount;
    logic          avalon_rd_waitrequest;
    logic          avalon_rd_readdatavalid;
    logic [DW-1:0] avalon_rd_readdata;
    logic [2:0]    pending;
    logic          err_unexpected;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_rd_burst_arbiter #(.AW(AW), .DW(DW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_burstcount(rq0_burstcount),
        .rq0_waitrequest(rq0_waitrequest), .rq0_readdatavalid(rq0_readdatavalid),
        .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_burstcount(rq1_burstcount),
        .rq1_waitrequest(rq1_waitrequest), .rq1_readdatavalid(rq1_readdatavalid),
        .rq_read_data(rq_read_data),
        .avalon_rd_address(avalon_rd_address), .avalon_rd_read(avalon_rd_read),
        .avalon_rd_burstcount(avalon_rd_burstcount),
        .avalon_rd_waitrequest(avalon_rd_waitrequest),
        .avalon_rd_readdatavalid(avalon_rd_readdatavalid),
        .avalon_rd_readdata(avalon_rd_readdata),
        .pending(pending), .err_unexpected(err_unexpected)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rq0_address = '0; rq1_address = '0; rq0_read = 1'b0; rq1_read = 1'b0;
        rq0_burstcount = '0; rq1_burstcount = '0;
        avalon_rd_waitrequest = 1'b0; avalon_rd_readdatavalid = 1'b0; avalon_rd_readdata = '0;
        #2;
        checks++; if (avalon_rd_read !== 1'b0) begin errors++; $display("FAIL rst_read got=%0h exp=0", avalon_rd_read); end
        checks++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b11) begin errors++; $display("FAIL rst_wait got=%b exp=11", {rq1_waitrequest, rq0_waitrequest}); end
        checks++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv got=%b exp=00", {rq1_readdatavalid, rq0_readdatavalid}); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rst_pending got=%0d exp=0", pending); end
        checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err_unexpected); end
        checks++; if (avalon_rd_address !== 17'h0 || avalon_rd_burstcount !== 6'd0) begin errors++; $display("FAIL rst_addr_bc got=%0h/%0d exp=0/0", avalon_rd_address, avalon_rd_burstcount); end
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        int n0, n1;
        logic [DW-1:0] exp_d;
        n0 = 0; n1 = 0;
        rq0_address = 17'h100; rq0_burstcount = 6'd8; rq0_read = 1'b1;
        #1;
        checks++; if (avalon_rd_read !== 1'b0 || rq0_waitrequest !== 1'b1) begin errors++; $display("FAIL single_idle got=%0h/%0h exp=0/1", avalon_rd_read, rq0_waitrequest); end
        step();
        checks++; if (avalon_rd_read !== 1'b1) begin errors++; $display("FAIL single_fwd_read got=%0h exp=1", avalon_rd_read); end
        checks++; if (avalon_rd_address !== 17'h100 || avalon_rd_burstcount !== 6'd8) begin errors++; $display("FAIL single_fwd got=%0h/%0d exp=100/8", avalon_rd_address, avalon_rd_burstcount); end
        checks++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b10) begin errors++; $display("FAIL single_wait got=%b exp=10", {rq1_waitrequest, rq0_waitrequest}); end
        step();
        rq0_read = 1'b0;
        #1;
        checks++; if (pending !== 3'd1 || avalon_rd_read !== 1'b0) begin errors++; $display("FAIL single_pend got=%0d/%0h exp=1/0", pending, avalon_rd_read); end
        for (int i = 0; i < 8; i++) begin
            exp_d = 16'hA000 + 16'(i);
            avalon_rd_readdatavalid = 1'b1; avalon_rd_readdata = exp_d;
            #1;
            if (rq0_readdatavalid) n0++;
            if (rq1_readdatavalid) n1++;
            checks++; if (rq_read_data !== exp_d) begin errors++; $display("FAIL single_data got=%0h exp=%0h", rq_read_data, exp_d); end
            if (i == 7) begin
                checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pend_last got=%0d exp=1", pending); end
            end
            step();
        end
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (n0 != 8 || n1 != 0) begin errors++; $display("FAIL single_count got=%0d/%0d exp=8/0", n0, n1); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pend_done got=%0d exp=0", pending); end
    endtask

    task automatic test_round_robin_full();
        logic g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic ids [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [AW-1:0] exp_a;
        reset = 1'b1; #1; reset = 1'b0;
        rq0_address = 17'h200; rq1_address = 17'h300;
        rq0_burstcount = 6'd4; rq1_burstcount = 6'd4;
        rq0_read = 1'b1; rq1_read = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_a = g[k] ? 17'h300 : 17'h200;
            checks++; if (avalon_rd_read !== 1'b1 || avalon_rd_address !== exp_a) begin errors++; $display("FAIL rr_grant%0d got=%0h/%0h exp=1/%0h", k, avalon_rd_read, avalon_rd_address, exp_a); end
            checks++; if ({rq1_waitrequest, rq0_waitrequest} !== {!g[k], g[k]}) begin errors++; $display("FAIL rr_wait%0d got=%b exp=%b", k, {rq1_waitrequest, rq0_waitrequest}, {!g[k], g[k]}); end
            step();
        end
        rq1_read = 1'b0;
        #1;
        checks++; if (pending !== 3'd4 || avalon_rd_read !== 1'b0 || rq0_waitrequest !== 1'b1) begin errors++; $display("FAIL full_hold got=%0d/%0h/%0h exp=4/0/1", pending, avalon_rd_read, rq0_waitrequest); end
        step();
        checks++; if (avalon_rd_read !== 1'b0) begin errors++; $display("FAIL full_idle got=%0h exp=0", avalon_rd_read); end
        for (int i = 0; i < 4; i++) begin
            avalon_rd_readdatavalid = 1'b1; avalon_rd_readdata = 16'(16'hB000 + i);
            #1;
            checks++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b01 || avalon_rd_read !== 1'b0) begin errors++; $display("FAIL full_drain%0d got=%b/%0h exp=01/0", i, {rq1_readdatavalid, rq0_readdatavalid}, avalon_rd_read); end
            step();
        end
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (pending !== 3'd3 || avalon_rd_read !== 1'b0) begin errors++; $display("FAIL full_prepop got=%0d/%0h exp=3/0", pending, avalon_rd_read); end
        step();
        checks++; if (avalon_rd_read !== 1'b1 || avalon_rd_address !== 17'h200) begin errors++; $display("FAIL full_reissue got=%0h/%0h exp=1/200", avalon_rd_read, avalon_rd_address); end
        step();
        rq0_read = 1'b0;
        #1;
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", pending); end
        for (int i = 0; i < 16; i++) begin
            avalon_rd_readdatavalid = 1'b1;
            #1;
            checks++; if ({rq1_readdatavalid, rq0_readdatavalid} !== {ids[i/4], !ids[i/4]}) begin errors++; $display("FAIL rr_route%0d got=%b exp=%b", i, {rq1_readdatavalid, rq0_readdatavalid}, {ids[i/4], !ids[i/4]}); end
            step();
        end
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rr_empty got=%0d exp=0", pending); end
    endtask

    task automatic test_backpressure();
        logic ids [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rq1_address = 17'h3A0; rq1_burstcount = 6'd5; rq1_read = 1'b1;
        step();
        rq0_address = 17'h111; rq0_burstcount = 6'd2; rq0_read = 1'b1;
        avalon_rd_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (avalon_rd_address !== 17'h3A0 || avalon_rd_burstcount !== 6'd5 || avalon_rd_read !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got=%0h/%0d/%0h exp=3a0/5/1", i, avalon_rd_address, avalon_rd_burstcount, avalon_rd_read); end
            checks++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b11) begin errors++; $display("FAIL bp_wait%0d got=%b exp=11", i, {rq1_waitrequest, rq0_waitrequest}); end
            step();
        end
        avalon_rd_waitrequest = 1'b0;
        #1;
        checks++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b01 || avalon_rd_address !== 17'h3A0) begin errors++; $display("FAIL bp_release got=%b/%0h exp=01/3a0", {rq1_waitrequest, rq0_waitrequest}, avalon_rd_address); end
        step();
        rq1_read = 1'b0;
        #1;
        checks++; if (avalon_rd_address !== 17'h111 || rq0_waitrequest !== 1'b0) begin errors++; $display("FAIL bp_next got=%0h/%0h exp=111/0", avalon_rd_address, rq0_waitrequest); end
        step();
        rq0_read = 1'b0;
        #1;
        checks++; if (pending !== 3'd2) begin errors++; $display("FAIL bp_pend got=%0d exp=2", pending); end
        step();
        for (int i = 0; i < 7; i++) begin
            avalon_rd_readdatavalid = 1'b1;
            #1;
            checks++; if ({rq1_readdatavalid, rq0_readdatavalid} !== {ids[i], !ids[i]}) begin errors++; $display("FAIL bp_route%0d got=%b exp=%b", i, {rq1_readdatavalid, rq0_readdatavalid}, {ids[i], !ids[i]}); end
            step();
        end
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL bp_empty got=%0d exp=0", pending); end
    endtask

    task automatic test_bc0();
        rq0_burstcount = 6'd0; rq0_read = 1'b1;
        step();
        checks++; if (avalon_rd_read !== 1'b0 || rq0_waitrequest !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL bc0_cycle got=%0h/%0h/%0d exp=0/0/0", avalon_rd_read, rq0_waitrequest, pending); end
        step();
        rq0_read = 1'b0;
        #1;
        checks++; if (pending !== 3'd0 || avalon_rd_read !== 1'b0) begin errors++; $display("FAIL bc0_after got=%0d/%0h exp=0/0", pending, avalon_rd_read); end
        step();
        checks++; if (rq0_waitrequest !== 1'b1) begin errors++; $display("FAIL bc0_idle got=%0h exp=1", rq0_waitrequest); end
    endtask

    task automatic test_error();
        avalon_rd_readdatavalid = 1'b1;
        #1;
        checks++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00 || err_unexpected !== 1'b0) begin errors++; $display("FAIL err_drop got=%b/%0h exp=00/0", {rq1_readdatavalid, rq0_readdatavalid}, err_unexpected); end
        step();
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_set got=%0h exp=1", err_unexpected); end
        step(); step();
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0h exp=1", err_unexpected); end
    endtask

    task automatic test_reset_mid_burst();
        rq0_address = 17'h40; rq0_burstcount = 6'd8; rq0_read = 1'b1;
        step();
        step();
        avalon_rd_waitrequest = 1'b1;
        for (int i = 0; i < 2; i++) begin
            avalon_rd_readdatavalid = 1'b1;
            #1;
            checks++; if (rq0_readdatavalid !== 1'b1) begin errors++; $display("FAIL mid_beat%0d got=%0h exp=1", i, rq0_readdatavalid); end
            step();
        end
        #1;
        checks++; if (pending !== 3'd1 || avalon_rd_read !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%0h exp=1/1", pending, avalon_rd_read); end
        reset = 1'b1;
        #1;
        checks++; if (pending !== 3'd0 || err_unexpected !== 1'b0 || avalon_rd_read !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%0h/%0h exp=0/0/0", pending, err_unexpected, avalon_rd_read); end
        checks++; if ({rq1_waitrequest, rq0_waitrequest, rq1_readdatavalid, rq0_readdatavalid} !== 4'b1100) begin errors++; $display("FAIL mid_rst_hs got=%b exp=1100", {rq1_waitrequest, rq0_waitrequest, rq1_readdatavalid, rq0_readdatavalid}); end
        step();
        reset = 1'b0; rq0_read = 1'b0; avalon_rd_waitrequest = 1'b0;
        #1;
        checks++; if (rq0_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_orphan got=%0h exp=0", rq0_readdatavalid); end
        step();
        avalon_rd_readdatavalid = 1'b0;
        #1;
        checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL mid_err got=%0h exp=1", err_unexpected); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin_full();
        test_backpressure();
        test_bc0();
        test_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_rd_burst_arbiter.md
# avalon_rd_burst_arbiter

Two-port round-robin arbiter that shares one Avalon-MM burst read master between two line-fetch requesters. It sits between the requesters and the read side of the Avalon bridge. It serialises burst read commands and tracks outstanding bursts in an in-order tag FIFO. Each returning read beat is routed to the requester that issued the burst.

## Interface
- AW, 17, address width
- DW, 16, data width
- MAX_PENDING, 4, maximum outstanding accepted bursts (power of 2, ≥2)
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- rq0_address / rq1_address  in  AW  requester burst start address
- rq0_read / rq1_read  in  1  requester read command
- rq0_burstcount / rq1_burstcount  in  6  beats requested, 1..32
- rq0_waitrequest / rq1_waitrequest  out  1  command not accepted this cycle
- rq0_readdatavalid / rq1_readdatavalid  out  1  beat for this requester
- rq_read_data  out  DW  returning data, shared by both requesters
- avalon_rd_address  out  AW  forwarded address
- avalon_rd_read  out  1  forwarded read
- avalon_rd_burstcount  out  6  forwarded burstcount
- avalon_rd_waitrequest  in  1  fabric stall
- avalon_rd_readdatavalid  in  1  fabric beat valid
- avalon_rd_readdata  in  DW  fabric data
- pending  out  clog2(MAX_PENDING)+1  bursts accepted but not fully returned
- err_unexpected  out  1  sticky flag: beat received with no outstanding burst

## Operation
- FSM states: IDLE, BUSY0, BUSY1. Reset enters IDLE.
- IDLE
  - avalon_rd_read=0; both rqN_waitrequest=1.
  - If the FIFO is not full and any rqN_read is high, register a grant and go to BUSYn.
  - When both requesters assert, pick the one that is not last_grant. last_grant resets to 1, so rq0 wins the first tie.
- BUSYn
  - Forward rqN address, read and burstcount combinationally.
  - rqN_waitrequest = avalon_rd_waitrequest. The other requester's waitrequest is 1.
- Acceptance: BUSYn && rqN_read && !avalon_rd_waitrequest.
  - Push {id=n, burstcount} into the tag FIFO and set last_grant=n.
  - Next state, evaluated with the post-push FIFO level:
    - full → IDLE;
    - else other requester reading → BUSYother;
    - else rqN still reading → BUSYn;
    - else IDLE.
- Burstcount 0 in BUSYn:
  - Not forwarded: avalon_rd_read=0 and rqN_waitrequest=0 for that cycle.
  - No push, no data returned.
  - Next state follows the acceptance rules.
- rqN_read dropped while in BUSYn (protocol violation): avalon_rd_read follows it low, and the FSM returns to IDLE next cycle.
- Return path
  - rq_read_data = avalon_rd_readdata, passed through combinationally.
  - On avalon_rd_readdatavalid, rqK_readdatavalid=1 only for K = head.id.
  - A beat counter loads head.burstcount and decrements on each beat. The FIFO pops on the last beat.
- Beat with empty FIFO: dropped, and err_unexpected is set until reset.
- A push and a pop in the same cycle are both performed; pending is unchanged.
- The full check always uses the pre-pop level: a pop in the same cycle does not unblock a push.
- pending = FIFO occupancy; the pointers wrap modulo MAX_PENDING.

## Timing
- Reset values:
  - avalon_rd_read=0; rq0_waitrequest=rq1_waitrequest=1; rq*_readdatavalid=0.
  - pending=0; err_unexpected=0; beat counter=0.
  - avalon_rd_address/burstcount=0 (rq0 values muxed when not BUSY1).
- Arbitration latency:
  - 1 cycle from IDLE to first forwarded command.
  - Back-to-back commands from BUSY have no dead cycle.
- Command path (rq → avalon) is combinational within BUSYn; accepted on the same edge as the fabric.
- Return path: zero latency, combinational routing.
- Reset mid-burst: FIFO and counters clear. Beats arriving afterwards set err_unexpected, which is the correct flag since the bursts were abandoned.

## Test plan
- Single request: rq0 reads addr 0x100, bc=8, no fabric stall → avalon_rd_read high 1 cycle after rq0_read. Exactly 8 rq0_readdatavalid pulses; pending 1→0 after the 8th beat.
- Tie and round-robin: both request bc=4 continuously → grants alternate rq0, rq1, rq0, rq1 on consecutive accepted cycles. Returned beats are routed 4/4/4/4 in issue order.
- Backpressure: avalon_rd_waitrequest high 3 cycles during BUSY1 → address and burstcount held stable, rq1_waitrequest high 3 cycles, rq0 never granted meanwhile.
- Full: MAX_PENDING=4 bursts accepted with no data returned → pending=4, FSM in IDLE, avalon_rd_read=0. After the first burst completes, the next command issues 1 cycle later.
- Burstcount 0: rq0 bc=0 → one-cycle rq0_waitrequest=0, no avalon_rd_read, pending unchanged.
- Error/reset: readdatavalid with pending=0 → err_unexpected=1 and held. Reset asserted mid-burst → all outputs return to their reset values asynchronously.
